// File: rtl/autosym_pkg.sv
// Shared types and sizing helpers for the autosymmetric PLA evaluator.
package autosym_pkg;

   localparam int DEF_N_IN    = 23;
   localparam int DEF_K_RED   = 8;
   localparam int DEF_N_CUBES = 64;
   localparam int DEF_LANES   = 4;

   typedef enum logic [1:0] {
      S_IDLE,
      S_PROJ,
      S_SCAN,
      S_DONE
   } state_t;

   // One product term of f_k over the reduced variables z.
   typedef struct packed {
      logic                 valid;
      logic [DEF_K_RED-1:0] mask;
      logic [DEF_K_RED-1:0] value;
   } cube_t;

   function automatic int num_groups(input int n_cubes, input int lanes);
      return n_cubes / lanes;
   endfunction

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/autosym_cube_match.sv
// Combinational comparison of one group of LANES cubes against the reduced vector z;
// reports whether any lane hits and the lowest hitting lane.
module autosym_cube_match
   import autosym_pkg::*;
#(
   parameter int LANES  = DEF_LANES,
   parameter int LANE_W = idx_w(LANES)
) (
   input  logic [DEF_K_RED-1:0] z,
   input  cube_t [LANES-1:0]    cubes,
   output logic                 hit,
   output logic [LANE_W-1:0]    lane
);

   always_comb begin
      // NOTE: combinational logic uses blocking assignments with every output defaulted first, so no latch is inferred.
      hit  = 1'b0;
      lane = '0;
      // Walk downward so the lowest hitting lane is the one left standing.
      for (int l = LANES - 1; l >= 0; l--) begin
         if (cubes[l].valid && (((z ^ cubes[l].value) & cubes[l].mask) == '0)) begin
            hit  = 1'b1;
            lane = LANE_W'(l);
         end
      end
   end

endmodule

// File: rtl/autosym_pla_eval.sv
// Autosymmetric function evaluator: GF(2) projection z = beta*x followed by a cube-table scan.
// Optional feature macro: AUTOSYM_EARLY_EXIT_EN ends the scan at the first hitting group.
module autosym_pla_eval
   import autosym_pkg::*;
#(
   parameter int  N_IN    = DEF_N_IN,
   parameter int  K_RED   = DEF_K_RED,
   parameter int  N_CUBES = DEF_N_CUBES,
   parameter int  LANES   = DEF_LANES,
   parameter int  CFG_W   = (N_IN > 2 * K_RED + 1) ? N_IN : 2 * K_RED + 1,
   localparam int ADDR_W  = idx_w(K_RED + N_CUBES),
   localparam int CUBE_W  = idx_w(N_CUBES)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cfg_we,
   input  logic [ADDR_W-1:0] cfg_addr,
   input  logic [CFG_W-1:0]  cfg_wdata,
   output logic              cfg_err,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [N_IN-1:0]   in_x,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_y,
   output logic [CUBE_W-1:0] out_cube
);

   localparam int G      = num_groups(N_CUBES, LANES);
   localparam int G_W    = idx_w(G);
   localparam int LANE_W = idx_w(LANES);

`ifdef AUTOSYM_EARLY_EXIT_EN
   localparam bit EARLY_EXIT = 1'b1;
`else
   localparam bit EARLY_EXIT = 1'b0;
`endif

   // The packed cube entry is sized by the package, so the reduced width must agree with it.
   if (K_RED != DEF_K_RED) begin : g_bad_k_red
      $error("autosym_pla_eval: K_RED must equal autosym_pkg::DEF_K_RED");
   end

   state_t              state_q, state_d;
   logic [N_IN-1:0]     x_reg;
   logic [K_RED-1:0]    z_reg, z_next;
   logic [G_W-1:0]      g_q;
   logic                y_q;
   logic [CUBE_W-1:0]   cube_q;
   logic                err_q;
   logic [N_IN-1:0]     beta     [K_RED];
   cube_t               cube_mem [N_CUBES];
   cube_t [LANES-1:0]   grp;
   logic                hit;
   logic [LANE_W-1:0]   lane;
   logic                last_group;
   logic                addr_ok;

   always_comb begin
      for (int i = 0; i < K_RED; i++) begin
         z_next[i] = ^(beta[i] & x_reg);
      end
   end

   always_comb begin
      for (int l = 0; l < LANES; l++) begin
         grp[l] = cube_mem[CUBE_W'(int'(g_q) * LANES + l)];
      end
   end

   autosym_cube_match #(
      .LANES (LANES),
      .LANE_W(LANE_W)
   ) u_match (
      .z    (z_reg),
      .cubes(grp),
      .hit  (hit),
      .lane (lane)
   );

   assign last_group = (g_q == G_W'(G - 1));

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: if (in_valid) state_d = S_PROJ;
         S_PROJ: state_d = S_SCAN;
         S_SCAN: if (last_group || (EARLY_EXIT && hit)) state_d = S_DONE;
         S_DONE: if (out_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state is updated with non-blocking assignments so every register samples pre-edge values.
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_reg  <= '0;
         z_reg  <= '0;
         g_q    <= '0;
         y_q    <= 1'b0;
         cube_q <= '0;
      end else begin
         unique case (state_q)
            S_IDLE: if (in_valid) x_reg <= in_x;
            S_PROJ: begin
               z_reg  <= z_next;
               g_q    <= '0;
               y_q    <= 1'b0;
               cube_q <= '0;
            end
            S_SCAN: begin
               g_q <= g_q + 1'b1;
               if (hit && !y_q) begin
                  y_q    <= 1'b1;
                  cube_q <= CUBE_W'(int'(g_q) * LANES + int'(lane));
               end
            end
            default: ;
         endcase
      end
   end

   assign addr_ok = (int'(cfg_addr) < K_RED + N_CUBES);

   // NOTE: the tables are flops, not RAM, so they are reset: an empty table must evaluate to 0 after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
         for (int i = 0; i < K_RED; i++)   beta[i]     <= '0;
         for (int c = 0; c < N_CUBES; c++) cube_mem[c] <= '0;
      end else begin
         err_q <= cfg_we && ((state_q != S_IDLE) || !addr_ok);
         if (cfg_we && (state_q == S_IDLE)) begin
            for (int i = 0; i < K_RED; i++) begin
               if (int'(cfg_addr) == i) beta[i] <= cfg_wdata[N_IN-1:0];
            end
            for (int c = 0; c < N_CUBES; c++) begin
               if (int'(cfg_addr) == K_RED + c) cube_mem[c] <= cube_t'(cfg_wdata[2*K_RED:0]);
            end
         end
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign out_y     = y_q;
   assign out_cube  = cube_q;
   assign cfg_err   = err_q;

endmodule
